// File: rtl/fm_wm_adj_accum_memory.sv
// fm_wm_adj_accum_memory
// Row-organised result memory for the FM x WM x ADJ aggregation stage.
// Holds NUM_ROWS rows of NUM_COLS signed words. A row write either
// overwrites the row or adds into it with signed saturation, so neighbour
// contributions can be summed in place. Reads are registered with a valid
// strobe. A sequenced clear engine re-zeroes the array one row per cycle
// between layers, without needing a global reset.
//
// Ports
//   clk, rst     : clock and synchronous active-high reset
//   wr_valid     : write request; accepted when wr_valid && wr_ready
//   wr_ready     : high in IDLE when not in reset
//   wr_mode      : 0 = overwrite, 1 = saturating accumulate
//   wr_row       : target row
//   wr_data      : NUM_COLS signed words
//   rd_req       : read request; answered one cycle later
//   rd_row       : row to read
//   rd_valid     : rd_data holds the answer to last cycle's rd_req
//   rd_data      : registered row data (0 for an out-of-range row)
//   clear_start  : pulse that starts a clear sweep (honoured in IDLE only)
//   clear_busy   : high for the NUM_ROWS cycles of the sweep
//   row_written  : per-row bit, set by a write, cleared by reset or sweep
//   sat_flag     : sticky, some accumulate column clamped
//   err_flag     : sticky, an out-of-range wr_row or rd_row was seen
module fm_wm_adj_accum_memory #(
  parameter int NUM_ROWS   = 6,
  parameter int NUM_COLS   = 3,
  parameter int DATA_WIDTH = 16,
  parameter int ROW_WIDTH  = $clog2(NUM_ROWS)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 wr_valid,
  output logic                                 wr_ready,
  input  logic                                 wr_mode,
  input  logic [ROW_WIDTH-1:0]                 wr_row,
  input  logic [0:NUM_COLS-1][DATA_WIDTH-1:0]  wr_data,
  input  logic                                 rd_req,
  input  logic [ROW_WIDTH-1:0]                 rd_row,
  output logic                                 rd_valid,
  output logic [0:NUM_COLS-1][DATA_WIDTH-1:0]  rd_data,
  input  logic                                 clear_start,
  output logic                                 clear_busy,
  output logic [NUM_ROWS-1:0]                  row_written,
  output logic                                 sat_flag,
  output logic                                 err_flag
);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  localparam logic [ROW_WIDTH-1:0] LAST_ROW = ROW_WIDTH'(NUM_ROWS - 1);

  state_t                              state;
  state_t                              state_next;
  logic [ROW_WIDTH-1:0]                clr_ptr;
  logic [0:NUM_COLS-1][DATA_WIDTH-1:0] mem [NUM_ROWS];

  logic                                wr_fire;
  logic                                wr_in_range;
  logic                                rd_in_range;
  logic                                clear_accept;
  logic [ROW_WIDTH-1:0]                wr_idx;
  logic [0:NUM_COLS-1][DATA_WIDTH-1:0] acc_row;
  logic [DATA_WIDTH:0]                 col_sum [NUM_COLS];
  logic [NUM_COLS-1:0]                 col_sat;

  assign wr_ready     = (state == IDLE) && !rst;
  assign clear_busy   = (state == CLEAR);
  assign wr_fire      = wr_valid && wr_ready;
  assign wr_in_range  = (int'(wr_row) < NUM_ROWS);
  assign rd_in_range  = (int'(rd_row) < NUM_ROWS);
  assign clear_accept = clear_start && (state == IDLE);
  // Keeps the accumulate read port inside the array for bad row numbers;
  // such writes are dropped anyway.
  assign wr_idx       = wr_in_range ? wr_row : '0;

  // State register for the clear sequencer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: start a sweep from IDLE, leave after the last row.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (clear_start)         state_next = CLEAR;
      CLEAR:   if (clr_ptr == LAST_ROW) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Sweep pointer walks the rows while clearing and parks at 0 otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      clr_ptr <= '0;
    end else if (state == CLEAR) begin
      clr_ptr <= (clr_ptr == LAST_ROW) ? '0 : clr_ptr + 1'b1;
    end else begin
      clr_ptr <= '0;
    end
  end

  // Saturating accumulate: add at DATA_WIDTH+1 bits; differing top two bits
  // mean overflow, and the extra sign bit tells which rail to clamp to.
  always_comb begin
    acc_row = '0;
    col_sat = '0;
    for (int c = 0; c < NUM_COLS; c++) begin
      col_sum[c] = {mem[wr_idx][c][DATA_WIDTH-1], mem[wr_idx][c]}
                 + {wr_data[c][DATA_WIDTH-1], wr_data[c]};
      if (col_sum[c][DATA_WIDTH] != col_sum[c][DATA_WIDTH-1]) begin
        col_sat[c] = 1'b1;
        acc_row[c] = col_sum[c][DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                            : {1'b0, {(DATA_WIDTH-1){1'b1}}};
      end else begin
        acc_row[c] = col_sum[c][DATA_WIDTH-1:0];
      end
    end
  end

  // Array, row_written and sticky flags. Writes are never accepted during
  // a sweep, so the write and sweep paths never target a row together.
  // An accepted clear_start wins over a same-cycle error or saturation.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NUM_ROWS; r++) begin
        mem[r] <= '0;
      end
      row_written <= '0;
      sat_flag    <= 1'b0;
      err_flag    <= 1'b0;
    end else begin
      if (wr_fire && wr_in_range) begin
        mem[wr_row]         <= wr_mode ? acc_row : wr_data;
        row_written[wr_row] <= 1'b1;
      end
      if (state == CLEAR) begin
        mem[clr_ptr]         <= '0;
        row_written[clr_ptr] <= 1'b0;
      end
      if (clear_accept) begin
        sat_flag <= 1'b0;
        err_flag <= 1'b0;
      end else begin
        if (wr_fire && wr_in_range && wr_mode && (|col_sat)) begin
          sat_flag <= 1'b1;
        end
        if ((wr_fire && !wr_in_range) || (rd_req && !rd_in_range)) begin
          err_flag <= 1'b1;
        end
      end
    end
  end

  // Registered read port; samples the array before this edge's write.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_req;
      if (rd_req) begin
        rd_data <= rd_in_range ? mem[rd_row] : '0;
      end
    end
  end

endmodule

// File: tb/tb_fm_wm_adj_accum_memory.sv
// tb_fm_wm_adj_accum_memory
// Self-checking bench for fm_wm_adj_accum_memory with default parameters
// (6 rows, 3 columns, 16-bit words). A behavioural model of the memory is
// updated at every rising edge from the driven inputs and compared against
// the DUT on every falling edge; directed sequences add literal checks.
module tb_fm_wm_adj_accum_memory;

  localparam int ROWS = 6;
  localparam int COLS = 3;
  localparam int MAXV = 32767;
  localparam int MINV = -32768;

  logic                 clk;
  logic                 rst;
  logic                 wr_valid;
  logic                 wr_ready;
  logic                 wr_mode;
  logic [2:0]           wr_row;
  logic [0:2][15:0]     wr_data;
  logic                 rd_req;
  logic [2:0]           rd_row;
  logic                 rd_valid;
  logic [0:2][15:0]     rd_data;
  logic                 clear_start;
  logic                 clear_busy;
  logic [5:0]           row_written;
  logic                 sat_flag;
  logic                 err_flag;

  int tests;
  int fails;
  bit checking;

  fm_wm_adj_accum_memory dut (
    .clk         (clk),
    .rst         (rst),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_mode     (wr_mode),
    .wr_row      (wr_row),
    .wr_data     (wr_data),
    .rd_req      (rd_req),
    .rd_row      (rd_row),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data),
    .clear_start (clear_start),
    .clear_busy  (clear_busy),
    .row_written (row_written),
    .sat_flag    (sat_flag),
    .err_flag    (err_flag)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Behavioural model: plain integer array, rows left to clear, flags.
  int       m_mem [ROWS][COLS];
  bit [5:0] m_rw;
  bit       m_sat;
  bit       m_err;
  int       m_clr_left;
  int       m_clr_idx;
  bit       m_rd_valid;
  int       m_rd_data [COLS];
  int       m_val;

  always @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++) m_mem[r][c] = 0;
      for (int c = 0; c < COLS; c++) m_rd_data[c] = 0;
      m_rw       = '0;
      m_sat      = 1'b0;
      m_err      = 1'b0;
      m_clr_left = 0;
      m_clr_idx  = 0;
      m_rd_valid = 1'b0;
    end else begin
      m_rd_valid = rd_req;
      if (rd_req) begin
        for (int c = 0; c < COLS; c++)
          m_rd_data[c] = (int'(rd_row) < ROWS) ? m_mem[rd_row][c] : 0;
        if (int'(rd_row) >= ROWS) m_err = 1'b1;
      end
      if (wr_valid && m_clr_left == 0) begin
        if (int'(wr_row) >= ROWS) begin
          m_err = 1'b1;
        end else begin
          for (int c = 0; c < COLS; c++) begin
            m_val = int'($signed(wr_data[c]));
            if (wr_mode) m_val = m_val + m_mem[wr_row][c];
            if (m_val > MAXV) begin m_val = MAXV; m_sat = 1'b1; end
            if (m_val < MINV) begin m_val = MINV; m_sat = 1'b1; end
            m_mem[wr_row][c] = m_val;
          end
          m_rw[wr_row] = 1'b1;
        end
      end
      if (m_clr_left > 0) begin
        for (int c = 0; c < COLS; c++) m_mem[m_clr_idx][c] = 0;
        m_rw[m_clr_idx] = 1'b0;
        m_clr_idx++;
        m_clr_left--;
      end else if (clear_start) begin
        m_clr_left = ROWS;
        m_clr_idx  = 0;
        m_sat      = 1'b0;
        m_err      = 1'b0;
      end
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Compare process: every falling edge, DUT against model.
  always @(negedge clk) begin
    if (checking) begin
      checkOutput("model_wr_ready", int'(wr_ready), int'(!rst && m_clr_left == 0));
      checkOutput("model_clear_busy", int'(clear_busy), int'(m_clr_left > 0));
      checkOutput("model_rd_valid", int'(rd_valid), int'(m_rd_valid));
      checkOutput("model_row_written", int'(row_written), int'(m_rw));
      checkOutput("model_sat_flag", int'(sat_flag), int'(m_sat));
      checkOutput("model_err_flag", int'(err_flag), int'(m_err));
      if (m_rd_valid) begin
        for (int c = 0; c < COLS; c++)
          checkOutput("model_rd_data", int'($signed(rd_data[c])), m_rd_data[c]);
      end
    end
  end

  // Drive one cycle of inputs just after a falling edge, then wait for the
  // next falling edge so outputs of the intervening rising edge are visible.
  task automatic applyStimulus(input logic v, input logic mode, input logic [2:0] row,
                               input int d0, input int d1, input int d2,
                               input logic rq, input logic [2:0] rrow, input logic cs);
    #1;
    wr_valid    = v;
    wr_mode     = mode;
    wr_row      = row;
    wr_data[0]  = d0[15:0];
    wr_data[1]  = d1[15:0];
    wr_data[2]  = d2[15:0];
    rd_req      = rq;
    rd_row      = rrow;
    clear_start = cs;
    @(negedge clk);
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 1'b0, 3'd0, 0, 0, 0, 1'b0, 3'd0, 1'b0);
  endtask

  task automatic readRow(input logic [2:0] r);
    applyStimulus(1'b0, 1'b0, 3'd0, 0, 0, 0, 1'b1, r, 1'b0);
  endtask

  task automatic checkRow(input string name, input int e0, input int e1, input int e2);
    checkOutput({name, "_valid"}, int'(rd_valid), 1);
    checkOutput({name, "_c0"}, int'($signed(rd_data[0])), e0);
    checkOutput({name, "_c1"}, int'($signed(rd_data[1])), e1);
    checkOutput({name, "_c2"}, int'($signed(rd_data[2])), e2);
  endtask

  int cnt;

  initial begin
    tests = 0;
    fails = 0;
    checking = 1'b0;
    rst = 1'b1;
    wr_valid = 1'b0; wr_mode = 1'b0; wr_row = '0; wr_data = '0;
    rd_req = 1'b0; rd_row = '0; clear_start = 1'b0;

    // Reset state
    idleCycle();
    checking = 1'b1;
    idleCycle();
    checkOutput("reset_wr_ready", int'(wr_ready), 0);
    checkOutput("reset_rd_valid", int'(rd_valid), 0);
    checkOutput("reset_row_written", int'(row_written), 0);
    checkOutput("reset_rd_data", int'(rd_data), 0);
    #1 rst = 1'b0;
    idleCycle();
    checkOutput("post_reset_wr_ready", int'(wr_ready), 1);

    // Overwrite then read
    applyStimulus(1'b1, 1'b0, 3'd2, 5, -3, 7, 1'b0, 3'd0, 1'b0);
    readRow(3'd2);
    checkRow("ovw_row2", 5, -3, 7);
    checkOutput("ovw_row_written", int'(row_written), 6'b000100);
    idleCycle();
    checkOutput("rd_valid_single_cycle", int'(rd_valid), 0);

    // Accumulate chain on consecutive cycles
    applyStimulus(1'b1, 1'b0, 3'd0, 1, 2, 3, 1'b0, 3'd0, 1'b0);
    applyStimulus(1'b1, 1'b1, 3'd0, 10, 10, 10, 1'b0, 3'd0, 1'b0);
    applyStimulus(1'b1, 1'b1, 3'd0, 10, 10, 10, 1'b0, 3'd0, 1'b0);
    readRow(3'd0);
    checkRow("acc_chain", 21, 22, 23);
    checkOutput("acc_no_sat", int'(sat_flag), 0);

    // Saturation at both rails
    applyStimulus(1'b1, 1'b0, 3'd1, 32000, -32000, 0, 1'b0, 3'd0, 1'b0);
    applyStimulus(1'b1, 1'b1, 3'd1, 1000, -1000, 5, 1'b0, 3'd0, 1'b0);
    readRow(3'd1);
    checkRow("sat_row1", 32767, -32768, 5);
    checkOutput("sat_flag_set", int'(sat_flag), 1);

    // Same-cycle read and write: read-before-write
    applyStimulus(1'b1, 1'b0, 3'd3, 4, 4, 4, 1'b0, 3'd0, 1'b0);
    applyStimulus(1'b1, 1'b0, 3'd3, 9, 9, 9, 1'b1, 3'd3, 1'b0);
    checkRow("rbw_old", 4, 4, 4);
    readRow(3'd3);
    checkRow("rbw_new", 9, 9, 9);

    // Out-of-range write and read
    applyStimulus(1'b1, 1'b0, 3'd7, 1, 1, 1, 1'b0, 3'd0, 1'b0);
    checkOutput("oor_wr_err", int'(err_flag), 1);
    checkOutput("oor_wr_ready", int'(wr_ready), 1);
    readRow(3'd6);
    checkRow("oor_rd", 0, 0, 0);
    readRow(3'd0);
    checkRow("oor_unchanged_row0", 21, 22, 23);

    // Fill all rows, then a sequenced clear
    for (int r = 0; r < ROWS; r++)
      applyStimulus(1'b1, 1'b0, 3'(r), r + 1, -(r + 1), 100 * r, 1'b0, 3'd0, 1'b0);
    checkOutput("fill_row_written", int'(row_written), 6'b111111);
    applyStimulus(1'b0, 1'b0, 3'd0, 0, 0, 0, 1'b0, 3'd0, 1'b1);
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      if (!clear_busy) break;
      cnt++;
      checkOutput("clear_wr_ready_low", int'(wr_ready), 0);
      if (k == 2)
        applyStimulus(1'b1, 1'b0, 3'd5, 99, 99, 99, 1'b1, 3'd4, 1'b1);
      else
        idleCycle();
    end
    checkOutput("clear_busy_cycles", cnt, ROWS);
    checkOutput("clear_row_written", int'(row_written), 0);
    checkOutput("clear_sat_flag", int'(sat_flag), 0);
    checkOutput("clear_err_flag", int'(err_flag), 0);
    for (int r = 0; r < ROWS; r++) begin
      readRow(3'(r));
      checkRow("cleared_row", 0, 0, 0);
    end

    // Write and clear_start in the same IDLE cycle
    applyStimulus(1'b1, 1'b0, 3'd4, 7, 7, 7, 1'b0, 3'd0, 1'b1);
    checkOutput("wr_clear_busy", int'(clear_busy), 1);
    checkOutput("wr_clear_row_written", int'(row_written), 6'b010000);
    for (int k = 0; k < 20 && clear_busy; k++) idleCycle();
    readRow(3'd4);
    checkRow("wr_clear_wiped", 0, 0, 0);
    checkOutput("wr_clear_rw_after", int'(row_written), 0);

    // Reset in the middle of a sweep
    applyStimulus(1'b1, 1'b0, 3'd5, 11, 12, 13, 1'b0, 3'd0, 1'b0);
    applyStimulus(1'b0, 1'b0, 3'd0, 0, 0, 0, 1'b0, 3'd0, 1'b1);
    idleCycle();
    #1 rst = 1'b1;
    idleCycle();
    checkOutput("midclear_rst_busy", int'(clear_busy), 0);
    checkOutput("midclear_rst_ready", int'(wr_ready), 0);
    #1 rst = 1'b0;
    idleCycle();
    readRow(3'd5);
    checkRow("midclear_row5", 0, 0, 0);
    checkOutput("midclear_row_written", int'(row_written), 0);

    idleCycle();
    checking = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fm_wm_adj_accum_memory.md
# fm_wm_adj_accum_memory

Parametrised row-organised result memory for the FM×WM×ADJ aggregation stage. It stores NUM_ROWS rows of NUM_COLS signed dot-product words. Each row write either overwrites the row or accumulates into it with signed saturation, which lets neighbour contributions be summed in place. Reads are registered with a valid strobe, and a sequenced clear engine re-zeroes the array between layers without a global reset.

## Interface
Parameters:
- NUM_ROWS, 6, number of stored rows (≥2).
- NUM_COLS, 3, words per row (≥1).
- DATA_WIDTH, 16, signed word width (≥2).
- ROW_WIDTH, $clog2(NUM_ROWS), row index width.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  reset; synchronous, active-high.
- wr_valid  in  1  write request.
- wr_ready  out  1  write accepted when wr_valid && wr_ready.
- wr_mode  in  1  0 = overwrite, 1 = accumulate.
- wr_row  in  ROW_WIDTH  target row.
- wr_data  in  DATA_WIDTH × [0:NUM_COLS-1]  signed row data.
- rd_req  in  1  read request.
- rd_row  in  ROW_WIDTH  row to read.
- rd_valid  out  1  rd_data valid this cycle.
- rd_data  out  DATA_WIDTH × [0:NUM_COLS-1]  registered row data.
- clear_start  in  1  pulse: begin a sequenced clear.
- clear_busy  out  1  high while the clear engine runs.
- row_written  out  NUM_ROWS  per-row bit: written since last reset/clear.
- sat_flag  out  1  sticky: some accumulate saturated.
- err_flag  out  1  sticky: out-of-range wr_row or rd_row was seen.

## Operation
- FSM states:
  - IDLE → CLEAR on clear_start.
  - CLEAR holds a row counter clr_ptr that runs 0..NUM_ROWS-1 and zeroes one row per cycle. It also resets that row's row_written bit.
  - CLEAR → IDLE after row NUM_ROWS-1 is cleared.
  - clear_start during CLEAR is ignored.
- wr_ready = (state == IDLE) && !rst.
- Accepted write, overwrite mode: mem[wr_row][c] ← wr_data[c] for every column.
- Accepted write, accumulate mode:
  - mem[wr_row][c] ← sat(mem[wr_row][c] + wr_data[c]).
  - The add is signed at DATA_WIDTH+1 bits, then clamped to [−2^(DATA_WIDTH−1), 2^(DATA_WIDTH−1)−1].
  - Any clamped column sets sat_flag.
- Every accepted write sets row_written[wr_row].
- wr_row ≥ NUM_ROWS: the write is dropped (memory unchanged), err_flag is set, and wr_ready stays high.
- Read, rd_req && rd_row < NUM_ROWS: rd_data ← mem[rd_row] next cycle and rd_valid = 1.
- Read, rd_row ≥ NUM_ROWS: rd_data ← 0, rd_valid = 1, err_flag is set.
- Reads are served in every state, including CLEAR. They return the current array contents.
- Same-cycle read and write to the same row: the read returns the pre-write contents (read-before-write).
- Back-to-back accumulates to the same row on consecutive cycles must chain correctly. The second accumulate uses the first one's result because the array updates on the first edge.
- sat_flag and err_flag clear only on rst or on clear_start accepted in IDLE.

## Timing
- Write: single cycle. The array is updated at the edge where the handshake occurs.
- Read latency: 1 cycle. rd_valid is high exactly one cycle per rd_req.
- Clear: clear_busy rises the cycle after clear_start and stays high for exactly NUM_ROWS cycles. wr_ready is low for those same cycles.
- Write and clear_start in the same IDLE cycle: the write is accepted first, then the clear starts and wipes it.
- Reset values (rst high at an edge):
  - All mem words 0; rd_data all 0; rd_valid 0.
  - clear_busy 0, state IDLE, clr_ptr 0.
  - row_written all 0; sat_flag 0; err_flag 0; wr_ready 0 during rst.
- rst mid-clear aborts the sweep. All rows end up zero anyway.

## Test plan
- Overwrite then read: write row 2 = {5, −3, 7}; rd_req row 2 → one cycle later rd_valid = 1, rd_data = {5, −3, 7}; row_written = 6'b000100.
- Accumulate chain: overwrite row 0 = {1, 2, 3}, then accumulate {10, 10, 10} on two consecutive cycles → read gives {21, 22, 23}; sat_flag = 0.
- Saturation (DATA_WIDTH = 16): row 1 = {32000, −32000, 0}, accumulate {1000, −1000, 5} → {32767, −32768, 5}; sat_flag = 1.
- Clear: fill all 6 rows, then pulse clear_start → clear_busy high 6 cycles, wr_ready low for those cycles; every row then reads 0; row_written = 0; flags cleared.
- Same-cycle read and write to row 3 (old value {4, 4, 4}, new value {9, 9, 9}) → rd_data = {4, 4, 4}; a following read gives {9, 9, 9}.
- Out of range: write to row 7 (NUM_ROWS = 6) → memory unchanged, err_flag = 1; read of row 6 → rd_valid = 1, rd_data = 0.
